fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the decoder.
- Generates sequential PCs and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small queue and presents {instruction, pc} to the decoder over a valid/ready handshake.
- Handles branch redirects from downstream by flushing the queue and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (byte address, word aligned)
QUEUE_DEPTH, 4, instruction queue entries; also the cap on queue occupancy plus outstanding requests

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch byte address, word aligned
imem_resp_valid  in  1  response word valid, in request order, at most one per cycle
imem_resp_data  in  32  returned instruction word
redirect_valid  in  1  branch taken: restart fetch at redirect_pc
redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0
instr_valid  out  1  instruction available to decoder
instr_ready  in  1  decoder accepts instruction
instruction  out  32  instruction word at queue head
instr_pc  out  32  byte address of that instruction

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - pc = RESET_PC, queue empty, outstanding = 0, discard = 0, state FETCH.
  - imem_req_valid = 0 and instr_valid = 0 while rst is high.
  - instruction and instr_pc read 0 at reset.
- State FETCH:
  - Assert imem_req_valid when (queue_count + outstanding) < QUEUE_DEPTH, using registered values only (no same-cycle dequeue credit).
  - imem_req_addr = pc.
  - On req_valid && req_ready: pc += 4 (wraps modulo 2^32), outstanding += 1.
  - While req_valid is high and ready is low, the address must stay stable.
- Responses (FETCH):
  - Write {resp_data, pc_of_request} to the queue at the clock edge.
  - Decrement outstanding.
  - A separate in-flight PC FIFO, or equivalent tracking, provides pc_of_request.
- Redirect (any state; has priority over every other event that cycle):
  - Queue is flushed and pc <= redirect_pc.
  - discard <= outstanding + (request accepted this cycle) - (response arriving this cycle).
  - A response arriving in the redirect cycle is dropped.
  - Next state is DRAIN if that discard value is > 0, else FETCH.
  - instr_valid is forced 0 combinationally in the redirect cycle, so no decoder handshake happens then.
  - imem_req_valid is forced 0 in the redirect cycle.
- State DRAIN:
  - No requests issued.
  - Each response decrements discard and outstanding and is not enqueued.
  - Go to FETCH in the cycle after discard reaches 0.
  - A further redirect in DRAIN updates pc only; discard already covers all in-flight requests.
- Output side:
  - instr_valid = queue not empty && !redirect_valid.
  - instruction and instr_pc come from the head entry, registered, and are stable while valid && !ready.
  - Dequeue on valid && ready.
  - Enqueue and dequeue in the same cycle keep the count unchanged.
  - The queue never overflows, by the credit rule above.
  - No bypass: a response is visible on instr_valid at the earliest one cycle after it arrives.
- Latency:
  - With 1-cycle memory, the first request goes out in the cycle after rst falls and instr_valid rises 2 cycles after that.
  - Sustained 1 instruction/cycle requires QUEUE_DEPTH ≥ memory latency + 2.
- Reset mid-operation:
  - All state returns to reset values.
  - Responses arriving after reset for pre-reset requests are an integration error: memory must also be reset.
- Width rules:
  - outstanding, discard and queue_count are each clog2(QUEUE_DEPTH+1) bits.
  - Assertion: outstanding never exceeds QUEUE_DEPTH.

Decomposition:
- Package h2bp: fetch_state_t enum {FETCH, DRAIN}, INSTR_BYTES = 4, and the default RESET_PC constant.
- Sub-module fetch_queue: a parameterised synchronous FIFO with flush, holding {pc, instruction}, with count output.
  - Instantiated once for the instruction queue.
  - Optionally instantiated again as the in-flight PC FIFO.

Test Plan:
- Reset release, 1-cycle memory with req_ready = 1, decoder ready = 1: request addresses 0x0, 0x4, 0x8…; instr_valid rises in cycle 2; instr_pc increments by 4 each cycle once steady, at DEPTH 4.
- Decoder stalls (instr_ready = 0) for 10 cycles: queue fills to 4 and imem_req_valid drops; head instruction and instr_pc are held stable; on release, words drain in order with no loss or duplicate.
- Memory back-pressure, req_ready = 0 for 3 cycles: imem_req_addr is held at the same value, e.g. 0x10; pc advances only on acceptance.
- Redirect to 0x100 with 2 requests outstanding and 3-cycle memory:
  - Both stale responses are dropped and DRAIN is entered.
  - The first new request 0x100 is issued only after discard reaches 0.
  - The first delivered instr_pc is 0x100.
- Redirect in the same cycle as a response and a decoder handshake: instr_valid is 0 that cycle, the response is dropped, and the queue is empty the next cycle.
- rst asserted mid-stream with queue at 3: next cycle instr_valid = 0 and imem_req_valid = 0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/h2bp_pkg.sv
// Shared types and constants for the instruction fetch stage.
//
// Contents:
//   fetch_state_t    - fetch FSM states (FETCH issues requests, DRAIN swallows stale responses)
//   INSTR_BYTES      - size of one instruction word in bytes
//   DEFAULT_RESET_PC - default first fetch address after reset
//   word_align()     - clears the sub-word byte offset of an address
package h2bp;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Masking rather than slicing keeps every address bit nominally used.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(32'(INSTR_BYTES) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: parameterised synchronous FIFO with flush and occupancy count.
//
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset; clears pointers and storage
//   flush in   empties the FIFO; has priority over push and pop
//   push  in   write data into the tail (ignored when full)
//   data  in   WIDTH-bit write data
//   pop   in   remove the head entry (ignored when empty)
//   head  out  head entry, read straight from the storage registers
//   empty out  no entries held
//   count out  number of entries held, 0..DEPTH
module fetch_queue #(
    parameter int unsigned  DEPTH = 4,
    parameter int unsigned  WIDTH = 64,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    always_comb begin
        do_push = push && (count_q != CW'(DEPTH));
        do_pop  = pop && (count_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Storage is cleared so the head reads zero out of reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        head  = mem_q[rd_ptr_q];
        empty = (count_q == '0);
        count = count_q;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//
// Generates sequential word-aligned PCs, issues requests to instruction memory (valid/ready,
// in-order responses), buffers returned words with their PCs in a small queue and presents
// {instruction, pc} to the decoder. A redirect flushes the queue, restarts fetch at the new
// PC and discards responses still in flight for the old path.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req_valid    out  request valid
//   imem_req_ready    in   memory accepts request
//   imem_req_addr     out  request byte address (word aligned)
//   imem_resp_valid   in   response word valid (in request order, at most one per cycle)
//   imem_resp_data    in   response instruction word
//   redirect_valid    in   restart fetch at redirect_pc
//   redirect_pc       in   new fetch address (bits [1:0] ignored)
//   instr_valid       out  instruction available to the decoder
//   instr_ready       in   decoder accepts instruction
//   instruction       out  instruction word at queue head
//   instr_pc          out  byte address of that instruction
module fetch_unit
    import h2bp::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] queue_count;
    logic          queue_empty;
    logic [63:0]   queue_head;
    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          req_fire;
    logic          resp_take;
    logic          deq;
    logic [31:0]   resp_pc;

    // Credit check uses registered state only: a dequeue this cycle frees a slot next cycle.
    always_comb begin
        occupancy = {1'b0, queue_count} + {1'b0, outstanding_q};
        credit_ok = occupancy < (CW + 1)'(QUEUE_DEPTH);
    end

    always_comb begin
        imem_req_valid = !rst && !redirect_valid && (state_q == FETCH) && credit_ok;
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        // Responses are only kept in FETCH and never in a redirect cycle.
        resp_take      = imem_resp_valid && !redirect_valid && (state_q == FETCH);
        instr_valid    = !rst && !queue_empty && !redirect_valid;
        deq            = instr_valid && instr_ready;
        instruction    = queue_head[31:0];
        instr_pc       = queue_head[63:32];
    end

    // In FETCH every in-flight request lies on the current sequential path (a redirect always
    // drains first), so the oldest one was issued outstanding words behind pc.
    always_comb begin
        resp_pc = pc_q - (32'(outstanding_q) * INSTR_BYTES);
    end

    always_comb begin
        pc_d          = pc_q;
        discard_d     = discard_q;
        state_d       = state_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
            // Everything still in flight after this edge belongs to the old path. In DRAIN
            // this equals discard minus any response now, since the two counters track.
            discard_d = outstanding_d;
            state_d   = (discard_d != '0) ? DRAIN : FETCH;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + INSTR_BYTES;
            end
            if (state_q == DRAIN) begin
                if (imem_resp_valid) begin
                    discard_d = discard_q - CW'(1);
                end
                if (discard_d == '0) begin
                    state_d = FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (64)
    ) u_instr_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (resp_take),
        .data  ({resp_pc, imem_resp_data}),
        .pop   (deq),
        .head  (queue_head),
        .empty (queue_empty),
        .count (queue_count)
    );

    outstanding_bound_a: assert property (@(posedge clk) disable iff (rst)
        outstanding_q <= CW'(QUEUE_DEPTH));

    occupancy_bound_a: assert property (@(posedge clk) disable iff (rst)
        occupancy <= (CW + 1)'(QUEUE_DEPTH));

    resp_has_request_a: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (outstanding_q != '0));

    drain_has_work_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == DRAIN) |-> ((discard_q != '0) && (discard_q <= outstanding_q)));

endmodule
